// File: rtl/q_stage_reg.sv
// rtl/q_stage_reg.sv - registered 3-share TI of the Midori64 quadratic layer Q, nibble-serial
module q_stage_reg #(
    parameter int NIBBLES = 16,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] x1,
    input  logic [3:0] x2,
    input  logic [3:0] x3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] y1,
    output logic [3:0] y2,
    output logic [3:0] y3,
    output logic       out_last
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NIBBLES - 1);

    // One output share of Q built only from its two permitted input shares.
    // sa supplies the linear bits and the "own" product term; sb is the other
    // share mixed into the cross terms. Keeping each share in its own call
    // guarantees non-completeness: no gate ever sees all three shares.
    function automatic logic [3:0] q_share(input logic [3:0] sa, input logic [3:0] sb);
        logic [3:0] r;
        r[3] = sa[3];
        r[2] = sa[2];
        r[1] = sa[1] ^ (sa[3] & sa[2]) ^ (sa[3] & sb[2]) ^ (sb[3] & sa[2]);
        r[0] = sa[0] ^ (sa[3] & sa[1]) ^ (sa[3] & sb[1]) ^ (sb[3] & sa[1]);
        return r;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic             out_last_q,  out_last_d;
    logic [3:0]       y1_q, y1_d;
    logic [3:0]       y2_q, y2_d;
    logic [3:0]       y3_q, y3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             transfer;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid_q && out_ready;

    // Next-state: flush wins over accept; data shares load only on accept.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        y3_d        = y3_q;
        cnt_d       = cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cnt_d       = '0;
        end else if (accept) begin
            y1_d        = q_share(x2, x3);
            y2_d        = q_share(x3, x1);
            y3_d        = q_share(x1, x2);
            out_valid_d = 1'b1;
            out_last_d  = (cnt_q == CNT_MAX);
            cnt_d       = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end else if (transfer) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Glitch-barrier register stage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            y1_q        <= 4'h0;
            y2_q        <= 4'h0;
            y3_q        <= 4'h0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            y3_q        <= y3_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign y1        = y1_q;
    assign y2        = y2_q;
    assign y3        = y3_q;

endmodule

// File: tb/tb_q_stage_reg.sv
// tb/tb_q_stage_reg.sv - self-checking bench for q_stage_reg
module tb_q_stage_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] x1, x2, x3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y1, y2, y3;
    logic       out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    bit       m_valid;
    bit       m_last;
    bit [3:0] m_y1, m_y2, m_y3, m_sum;
    int       m_count;

    q_stage_reg #(.NIBBLES(16), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .x3(x3),
        .out_valid(out_valid), .out_ready(out_ready),
        .y1(y1), .y2(y2), .y3(y3), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Unshared Q from its bit equations.
    function automatic bit [3:0] qref(input bit [3:0] x);
        bit [3:0] r;
        r[3] = x[3];
        r[2] = x[2];
        r[1] = x[1] ^ (x[3] & x[2]);
        r[0] = x[0] ^ (x[3] & x[1]);
        return r;
    endfunction

    // Share term of product a&b: own share i with partner j gives ai.bi ^ ai.bj ^ aj.bi.
    function automatic bit term(input bit ai, input bit bi, input bit aj, input bit bj);
        return (ai & bi) ^ (ai & bj) ^ (aj & bi);
    endfunction

    function automatic bit [3:0] share(input bit [3:0] own, input bit [3:0] other);
        return {own[3], own[2],
                own[1] ^ term(own[3], own[2], other[3], other[2]),
                own[0] ^ term(own[3], own[1], other[3], other[1])};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_last = 0; m_y1 = 0; m_y2 = 0; m_y3 = 0; m_sum = 0; m_count = 0;
    endtask

    // Called at a negedge: apply inputs, check in_ready, advance model, check outputs at next negedge.
    task automatic step(input bit iv, input bit [3:0] a, input bit [3:0] b, input bit [3:0] c,
                        input bit ordy, input bit fl);
        bit acc;
        in_valid = iv; x1 = a; x2 = b; x3 = c; out_ready = ordy; flush = fl;
        #1;
        check("in_ready", in_ready, !m_valid || ordy);
        acc = iv && (!m_valid || ordy);
        if (fl) begin
            m_valid = 0; m_last = 0; m_count = 0;
        end else if (acc) begin
            m_y1 = share(b, c);
            m_y2 = share(c, a);
            m_y3 = share(a, b);
            m_sum = qref(a ^ b ^ c);
            m_valid = 1;
            m_count = m_count + 1;
            m_last = (m_count % 16 == 0);
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        @(negedge clk);
        check("out_valid", out_valid, m_valid);
        check("y1", y1, m_y1);
        check("y2", y2, m_y2);
        check("y3", y3, m_y3);
        if (m_valid) begin
            check("xor_q", y1 ^ y2 ^ y3, m_sum);
            check("out_last", out_last, m_last);
        end
    endtask

    initial begin
        // reset with random inputs
        rst_n = 0; flush = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
        x1 = 4'($urandom); x2 = 4'($urandom); x3 = 4'($urandom);
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_y", {y1, y2, y3}, 0);
        rst_n = 1;
        step(0, 4'($urandom), 4'($urandom), 4'($urandom), 1, 0);
        step(0, 4'($urandom), 4'($urandom), 4'($urandom), 1, 0);
        check("idle_last", out_last, 0);

        // single nibble E -> D, then x1 toggled alone (y1 must not change)
        step(1, 4'h3, 4'h5, 4'h8, 1, 0);
        check("single_sum", y1 ^ y2 ^ y3, 4'hD);
        check("single_y1", y1, share(4'h5, 4'h8));
        step(1, 4'hC, 4'h5, 4'h8, 1, 0);
        check("noncomplete_y1", y1, share(4'h5, 4'h8));
        step(0, 0, 0, 0, 1, 0);

        // align counter, then exhaustive streaming
        rst_n = 0; #1; rst_n = 1; model_reset();
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] t;
            t = 12'(i);
            step(1, t[11:8], t[7:4], t[3:0], 1, 0);
            if (i % 16 == 15) check("last_16th", out_last, 1);
        end
        step(0, 0, 0, 0, 1, 0);
        check("q_0", qref(4'h0), 4'h0 ^ 0);

        // backpressure
        step(1, 4'($urandom), 4'($urandom), 4'($urandom), 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 4'($urandom), 4'($urandom), 4'($urandom), 0, 0);
            check("stall_in_ready", in_ready, 0);
        end
        for (int k = 0; k < 4; k++) step(1, 4'($urandom), 4'($urandom), 4'($urandom), 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // flush after 5 accepts, with in_valid high
        for (int k = 0; k < 5; k++) step(1, 4'($urandom), 4'($urandom), 4'($urandom), 1, 0);
        step(1, 4'($urandom), 4'($urandom), 4'($urandom), 1, 1);
        check("flush_valid", out_valid, 0);
        check("flush_last", out_last, 0);
        for (int k = 0; k < 16; k++) begin
            step(1, 4'($urandom), 4'($urandom), 4'($urandom), 1, 0);
            check("flush_count_last", out_last, k == 15);
        end
        step(0, 0, 0, 0, 1, 0);

        // async reset mid-stream
        for (int k = 0; k < 7; k++) step(1, 4'($urandom), 4'($urandom), 4'($urandom), 1, 0);
        check("pre_reset_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_last", out_last, 0);
        check("arst_y", {y1, y2, y3}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 16; k++) begin
            step(1, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, 0);
        end
        for (int k = 0; k < 20 && m_valid; k++) step(0, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
